button_event_arbiter: RTL and testbench

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_button_event_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//   Debounces four active-low push buttons, turns debounced transitions into
//   press / long-press / release events, and offers them one at a time to a
//   consumer through a valid/ready handshake with round-robin fairness.
//
// Ports
//   sysclk       in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   btn_n_i[3:0] in   raw asynchronous buttons, 0 = pressed
//   evt_valid_o  out  event offered
//   evt_ready_i  in   consumer takes the offered event
//   evt_btn_o    out  button index of offered event
//   evt_type_o   out  01 press, 10 release, 11 long-press
//   btn_state_o  out  debounced levels, 1 = pressed
//   overflow_o   out  sticky: an event merged into an already-pending one
//   clear_ovf_i  in   one-cycle pulse clearing overflow_o
module button_event_arbiter #(
  parameter int TICK_DIV   = 50000,
  parameter int DB_COUNT   = 10,
  parameter int LONG_COUNT = 100
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic [3:0] btn_n_i,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [1:0] evt_btn_o,
  output logic [1:0] evt_type_o,
  output logic [3:0] btn_state_o,
  output logic       overflow_o,
  input  logic       clear_ovf_i
);

  localparam int PW  = $clog2(TICK_DIV);
  localparam int DBW = $clog2(DB_COUNT + 1);
  localparam int HW  = $clog2(LONG_COUNT + 1);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  logic [3:0]    r_sync1, r_sync2;
  logic [PW-1:0] r_presc;
  logic          w_tick;

  logic [3:0] w_stable, w_fall, w_rise, w_long;
  logic [3:0] r_pend_press, r_pend_long, r_pend_rel;
  logic [3:0] w_has;

  state_t     r_state;
  logic       r_valid;
  logic [1:0] r_btn, r_type, r_last_grant;
  logic       r_ovf;

  logic       w_found, w_grant, w_ovf_set;
  logic [1:0] w_idx, w_sel_btn, w_sel_type;
  logic [3:0] w_sel_oh, w_clr_press, w_clr_long, w_clr_rel;

  // Two-flop synchronizer; idles at the released level.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= btn_n_i;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce sample prescaler.
  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge sysclk) begin
    if (!reset_n)    r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // Per-button debounce and hold timing.
  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic [DBW-1:0] r_db_cnt;
    logic           r_stable;   // 0 = pressed (active-low domain)
    logic [HW-1:0]  r_hold;
    logic           w_diff, w_upd;

    assign w_diff = r_sync2[gi] ^ r_stable;
    // Last disagreeing tick needed: the stable level flips on this tick.
    assign w_upd  = w_tick & w_diff & (r_db_cnt == DBW'(DB_COUNT - 1));

    assign w_fall[gi]   = w_upd & r_stable;
    assign w_rise[gi]   = w_upd & ~r_stable;
    // A release tick wins over the hold counter, so no long event then.
    assign w_long[gi]   = w_tick & ~r_stable & ~w_rise[gi] &
                          (r_hold == HW'(LONG_COUNT - 1));
    assign w_stable[gi] = r_stable;

    always_ff @(posedge sysclk) begin
      if (!reset_n) begin
        r_db_cnt <= '0;
        r_stable <= 1'b1;
        r_hold   <= '0;
      end else begin
        if (w_tick) begin
          if (!w_diff) begin
            r_db_cnt <= '0;
          end else if (w_upd) begin
            r_db_cnt <= '0;
            r_stable <= r_sync2[gi];
          end else begin
            r_db_cnt <= r_db_cnt + DBW'(1);
          end
        end
        if (w_rise[gi])
          r_hold <= '0;
        else if (w_tick && !r_stable && r_hold != HW'(LONG_COUNT))
          r_hold <= r_hold + HW'(1);
      end
    end
  end

  assign btn_state_o = ~w_stable;

  // Round-robin pick starting after the last granted button.
  assign w_has = r_pend_press | r_pend_long | r_pend_rel;

  always_comb begin
    w_found   = 1'b0;
    w_sel_btn = 2'd0;
    w_idx     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last_grant + 2'(k);
      if (!w_found && w_has[w_idx]) begin
        w_found   = 1'b1;
        w_sel_btn = w_idx;
      end
    end
  end

  always_comb begin
    if (r_pend_press[w_sel_btn])     w_sel_type = 2'b01;
    else if (r_pend_long[w_sel_btn]) w_sel_type = 2'b11;
    else                             w_sel_type = 2'b10;
  end

  assign w_grant     = (r_state == S_IDLE) & w_found;
  assign w_sel_oh    = 4'b0001 << w_sel_btn;
  assign w_clr_press = (w_grant && w_sel_type == 2'b01) ? w_sel_oh : 4'b0000;
  assign w_clr_long  = (w_grant && w_sel_type == 2'b11) ? w_sel_oh : 4'b0000;
  assign w_clr_rel   = (w_grant && w_sel_type == 2'b10) ? w_sel_oh : 4'b0000;

  // A set onto a bit that stays pending loses an event; a set onto a bit
  // being granted this cycle is a fresh event.
  assign w_ovf_set = |((w_fall & r_pend_press & ~w_clr_press) |
                       (w_long & r_pend_long  & ~w_clr_long)  |
                       (w_rise & r_pend_rel   & ~w_clr_rel));

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      r_pend_press <= '0;
      r_pend_long  <= '0;
      r_pend_rel   <= '0;
    end else begin
      r_pend_press <= (r_pend_press & ~w_clr_press) | w_fall;
      r_pend_long  <= (r_pend_long  & ~w_clr_long)  | w_long;
      r_pend_rel   <= (r_pend_rel   & ~w_clr_rel)   | w_rise;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset_n)         r_ovf <= 1'b0;
    else if (w_ovf_set)   r_ovf <= 1'b1;
    else if (clear_ovf_i) r_ovf <= 1'b0;
  end

  // Offer FSM: one event latched per grant, held until accepted.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_btn        <= 2'd0;
      r_type       <= 2'd0;
      r_last_grant <= 2'd3;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_OFFER;
            r_valid <= 1'b1;
            r_btn   <= w_sel_btn;
            r_type  <= w_sel_type;
          end
        end
        S_OFFER: begin
          if (evt_ready_i) begin
            r_state      <= S_IDLE;
            r_valid      <= 1'b0;
            r_last_grant <= r_btn;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign evt_valid_o = r_valid;
  assign evt_btn_o   = r_btn;
  assign evt_type_o  = r_type;
  assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter with TICK_DIV=4, DB_COUNT=3, LONG_COUNT=8.
// A behavioural model runs alongside every cycle; a vector table and a few
// hand sequences add fixed expectations for the documented scenarios.
module tb_button_event_arbiter;
  localparam int TD = 4, DB = 3, LC = 8;

  logic       sysclk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] btn_n_i = 4'hF;
  logic       evt_ready_i = 1'b1;
  logic       clear_ovf_i = 1'b0;
  logic       evt_valid_o, overflow_o;
  logic [1:0] evt_btn_o, evt_type_o;
  logic [3:0] btn_state_o;

  button_event_arbiter #(.TICK_DIV(TD), .DB_COUNT(DB), .LONG_COUNT(LC)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .btn_n_i(btn_n_i),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
    .evt_btn_o(evt_btn_o), .evt_type_o(evt_type_o),
    .btn_state_o(btn_state_o), .overflow_o(overflow_o),
    .clear_ovf_i(clear_ovf_i)
  );

  always #5 sysclk = ~sysclk;

  int n_chk = 0, n_fail = 0;
  logic [3:0] ev_q[$];   // accepted events as {btn, type}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per button: a count of consecutive disagreeing samples, a count of
  // ticks held, and a 3-slot pending set (press, long, release).
  bit [3:0]   m_s1, m_s2, m_stb;
  int         m_presc, m_lg;
  int         m_cnt[4], m_hold[4];
  bit         m_pend[4][3];
  bit         m_offer, m_ovf;
  logic [1:0] m_btn, m_type;

  function automatic logic [1:0] tcode(int t);
    return (t == 0) ? 2'b01 : (t == 1) ? 2'b11 : 2'b10;
  endfunction

  task automatic model_step();
    bit tick, newovf, ostb;
    bit clr[4][3];
    bit set[3];
    int sel_b, sel_t, b;
    if (!reset_n) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_stb = 4'hF; m_presc = 0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_hold[i] = 0;
        for (int t = 0; t < 3; t++) m_pend[i][t] = 0;
      end
      m_offer = 0; m_ovf = 0; m_btn = 0; m_type = 0; m_lg = 3;
      return;
    end
    tick = (m_presc == TD - 1);
    for (int i = 0; i < 4; i++) for (int t = 0; t < 3; t++) clr[i][t] = 0;
    sel_b = -1; sel_t = 0;
    if (!m_offer) begin
      for (int k = 1; k <= 4; k++) begin
        b = (m_lg + k) % 4;
        for (int t = 0; t < 3; t++)
          if (sel_b < 0 && m_pend[b][t]) begin sel_b = b; sel_t = t; end
      end
      if (sel_b >= 0) begin
        clr[sel_b][sel_t] = 1;
        m_offer = 1; m_btn = 2'(sel_b); m_type = tcode(sel_t);
      end
    end else if (evt_ready_i) begin
      m_offer = 0; m_lg = int'(m_btn);
    end
    newovf = 0;
    for (int i = 0; i < 4; i++) begin
      set[0] = 0; set[1] = 0; set[2] = 0;
      ostb = m_stb[i];
      if (tick) begin
        if (m_s2[i] != ostb) begin
          m_cnt[i]++;
          if (m_cnt[i] == DB) begin
            m_cnt[i] = 0;
            m_stb[i] = m_s2[i];
            if (ostb) set[0] = 1; else set[2] = 1;
          end
        end else m_cnt[i] = 0;
      end
      if (set[2]) m_hold[i] = 0;
      else if (tick && !ostb && m_hold[i] < LC) begin
        m_hold[i]++;
        if (m_hold[i] == LC) set[1] = 1;
      end
      for (int t = 0; t < 3; t++) begin
        if (set[t] && m_pend[i][t] && !clr[i][t]) newovf = 1;
        m_pend[i][t] = (m_pend[i][t] && !clr[i][t]) || set[t];
      end
    end
    if (newovf) m_ovf = 1;
    else if (clear_ovf_i) m_ovf = 0;
    m_presc = tick ? 0 : m_presc + 1;
    m_s2 = m_s1;
    m_s1 = btn_n_i;
  endtask

  // One clock: log a handshake, advance DUT and model, compare.
  task automatic cyc();
    if (reset_n && evt_valid_o && evt_ready_i) ev_q.push_back({evt_btn_o, evt_type_o});
    @(posedge sysclk);
    model_step();
    #1;
    chk("model {valid,btn,type,state,ovf}",
        {evt_valid_o, evt_btn_o, evt_type_o, btn_state_o, overflow_o},
        {m_offer, m_btn, m_type, ~m_stb, m_ovf});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    ev_q.delete();
  endtask

  typedef struct {
    logic [3:0] btn_n;
    int         cycles;
    logic [3:0] exp_state;
    int         exp_nev;
    logic [3:0] exp_last;   // {btn, type} of latest accepted event
  } vec_t;

  vec_t       tbl[13];
  logic [3:0] exp34[5];

  initial begin
    // bounce on btn0, accept press, release, short glitch on btn2, long hold on btn1
    tbl[0]  = '{4'hF, 10, 4'h0, 0, 4'h0};
    tbl[1]  = '{4'hE,  1, 4'h0, 0, 4'h0};
    tbl[2]  = '{4'hF,  1, 4'h0, 0, 4'h0};
    tbl[3]  = '{4'hE,  1, 4'h0, 0, 4'h0};
    tbl[4]  = '{4'hF,  1, 4'h0, 0, 4'h0};
    tbl[5]  = '{4'hE,  1, 4'h0, 0, 4'h0};
    tbl[6]  = '{4'hF,  1, 4'h0, 0, 4'h0};
    tbl[7]  = '{4'hE, 30, 4'h1, 1, 4'b0001};
    tbl[8]  = '{4'hF, 30, 4'h0, 2, 4'b0010};
    tbl[9]  = '{4'hB,  8, 4'h0, 2, 4'b0010};
    tbl[10] = '{4'hF, 30, 4'h0, 2, 4'b0010};
    tbl[11] = '{4'hD, 70, 4'h2, 4, 4'b0111};
    tbl[12] = '{4'hF, 30, 4'h0, 5, 4'b0110};
    exp34 = '{4'b0101, 4'b1101, 4'b0001, 4'b0110, 4'b1110};

    // reset state
    reset_n = 1'b0;
    repeat (3) cyc();
    chk("reset valid", evt_valid_o, 1'b0);
    chk("reset btn", evt_btn_o, 2'd0);
    chk("reset type", evt_type_o, 2'd0);
    chk("reset state", btn_state_o, 4'h0);
    chk("reset ovf", overflow_o, 1'b0);
    reset_n = 1'b1;
    ev_q.delete();

    // table-driven scenarios, consumer always ready
    for (int r = 0; r < 13; r++) begin
      btn_n_i = tbl[r].btn_n;
      repeat (tbl[r].cycles) cyc();
      chk($sformatf("tbl%0d state", r), btn_state_o, tbl[r].exp_state);
      chk($sformatf("tbl%0d nev", r), ev_q.size(), tbl[r].exp_nev);
      if (tbl[r].exp_nev > 0 && ev_q.size() > 0)
        chk($sformatf("tbl%0d last", r), ev_q[ev_q.size()-1], tbl[r].exp_last);
    end

    // simultaneous presses on 1 and 3 with a stalled consumer
    do_reset();
    evt_ready_i = 1'b0;
    btn_n_i = 4'b0101;
    repeat (18) cyc();
    chk("rr first offer", {evt_valid_o, evt_btn_o, evt_type_o}, 5'b1_01_01);
    btn_n_i = 4'b1110;   // release 1 and 3, press 0
    for (int c = 0; c < 20; c++) begin
      cyc();
      chk("rr offer held", {evt_valid_o, evt_btn_o, evt_type_o}, 5'b1_01_01);
    end
    evt_ready_i = 1'b1;
    repeat (20) cyc();
    chk("rr event count", ev_q.size(), 5);
    for (int k = 0; k < 5 && k < ev_q.size(); k++)
      chk($sformatf("rr order %0d", k), ev_q[k], exp34[k]);

    // double press/release on btn2 with no consumer -> overflow
    do_reset();
    evt_ready_i = 1'b0;
    chk("ovf initially clear", overflow_o, 1'b0);
    btn_n_i = 4'hB; repeat (20) cyc();
    btn_n_i = 4'hF; repeat (20) cyc();
    chk("ovf after one cycle of events", overflow_o, 1'b0);
    btn_n_i = 4'hB; repeat (20) cyc();
    btn_n_i = 4'hF; repeat (20) cyc();
    chk("ovf set", overflow_o, 1'b1);
    clear_ovf_i = 1'b1; cyc(); clear_ovf_i = 1'b0;
    chk("ovf cleared", overflow_o, 1'b0);

    // reset while an event is being offered
    btn_n_i = 4'hB; repeat (20) cyc();
    chk("pre-reset offer", {evt_valid_o, evt_btn_o, evt_type_o}, 5'b1_10_01);
    chk("pre-reset state", btn_state_o, 4'h4);
    chk("pre-reset ovf", overflow_o, 1'b1);
    do_reset();
    chk("post-reset valid", evt_valid_o, 1'b0);
    chk("post-reset ovf", overflow_o, 1'b0);
    chk("post-reset state", btn_state_o, 4'h0);

    // randomized traffic against the model
    btn_n_i = 4'hF;
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 19) == 0) btn_n_i[i] = ~btn_n_i[i];
      evt_ready_i = ($urandom_range(0, 3) != 0);
      clear_ovf_i = ($urandom_range(0, 49) == 0);
      reset_n     = ($urandom_range(0, 1999) != 0);
      cyc();
    end
    reset_n = 1'b1;
    clear_ovf_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
